// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - shared memory port arbiter between instruction fetch and data access.
// Data wins arbitration; a saturating starvation counter forces a fetch after STARVE_MAX data grants.
module mem_port_arb #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_flush,
  output logic            o_if_ack,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [AW-1:0]   i_dm_addr,
  input  logic [DW-1:0]   i_dm_wdata,
  input  logic [DW/8-1:0] i_dm_be,
  output logic            o_dm_ack,
  output logic [DW-1:0]   o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_be,
  input  logic            i_mem_ack,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_busy
);

  localparam int BW = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t          state_q;
  logic [3:0]      starve_q;
  logic            discard_q;
  logic            if_ack_q;
  logic [DW-1:0]   if_rdata_q;
  logic            dm_ack_q;
  logic [DW-1:0]   dm_rdata_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [BW-1:0]   mem_be_q;

  logic grant_dm_d;
  logic grant_if_d;
  logic [3:0] starve_d;

  assign grant_dm_d = i_dm_req && (!i_if_req || (starve_q < STARVE_LIM));
  assign grant_if_d = !grant_dm_d && i_if_req && !i_if_flush;
  assign starve_d   = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_ack_q    <= 1'b0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm_d) begin
            state_q     <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_dm_we;
            mem_addr_q  <= i_dm_addr;
            mem_wdata_q <= i_dm_wdata;
            mem_be_q    <= i_dm_be;
            starve_q    <= i_if_req ? starve_d : 4'd0;
          end else if (grant_if_d) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= {BW{1'b1}};
            starve_q    <= 4'd0;
          end else if (!i_if_req) begin
            starve_q <= 4'd0;
          end
        end
        IF_BUSY: begin
          // A flush in the ack cycle must also suppress the ack, hence the direct i_if_flush term.
          if (i_if_flush) discard_q <= 1'b1;
          if (i_mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            discard_q <= 1'b0;
            if (!discard_q && !i_if_flush) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= i_mem_rdata;
            end
          end
        end
        DM_BUSY: begin
          if (i_mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            dm_ack_q   <= 1'b1;
            dm_rdata_q <= mem_we_q ? '0 : i_mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_ack    = dm_ack_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb.
// Memory model returns addr ^ 0x113 as read data.
module tb_mem_port_arb;

  logic        clk;
  logic        i_reset_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_if_flush;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_be;
  logic        o_dm_ack;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  mem_port_arb dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .i_if_flush (i_if_flush),
    .o_if_ack   (o_if_ack),
    .o_if_rdata (o_if_rdata),
    .i_dm_req   (i_dm_req),
    .i_dm_we    (i_dm_we),
    .i_dm_addr  (i_dm_addr),
    .i_dm_wdata (i_dm_wdata),
    .i_dm_be    (i_dm_be),
    .o_dm_ack   (o_dm_ack),
    .o_dm_rdata (o_dm_rdata),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_be   (o_mem_be),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_busy     (o_busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  gnt_t        gnt_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];

  int checks = 0;
  int errors = 0;

  logic        mem_en = 1'b1;
  logic        stray_ack = 1'b0;
  logic        mack = 1'b0;
  logic [31:0] mem_rdata_m = '0;
  int          mem_delay = 0;
  int          mcnt = 0;

  assign i_mem_ack   = mem_en ? mack : stray_ack;
  assign i_mem_rdata = mem_rdata_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
    gnt_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.be = be;
    gnt_q.push_back(g);
  endtask

  // Zero-based wait: with mem_delay = 0 the ack comes in the first request cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        mack = 1'b0;
        mcnt = 0;
      end else if (mack) begin
        chk(o_mem_req == 1'b0, "req_drop_after_ack", 32'(o_mem_req), 32'd0);
        mack = 1'b0;
        mcnt = 0;
      end else if (o_mem_req) begin
        if (mcnt == mem_delay) begin
          mack = 1'b1;
          mem_rdata_m = o_mem_addr ^ 32'h0000_0113;
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  logic        prev_req = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_be;

  initial begin
    gnt_t g;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (o_mem_req && !prev_req) begin
        if (gnt_q.size() == 0) begin
          chk(1'b0, "grant_unexpected", o_mem_addr, 32'd0);
        end else begin
          g = gnt_q.pop_front();
          chk(o_mem_addr == g.addr, "grant_addr", o_mem_addr, g.addr);
          chk(o_mem_we == g.we, "grant_we", 32'(o_mem_we), 32'(g.we));
          chk(o_mem_be == g.be, "grant_be", 32'(o_mem_be), 32'(g.be));
          if (g.we) chk(o_mem_wdata == g.wdata, "grant_wdata", o_mem_wdata, g.wdata);
        end
        h_we = o_mem_we; h_addr = o_mem_addr; h_wdata = o_mem_wdata; h_be = o_mem_be;
      end else if (o_mem_req && prev_req) begin
        chk(o_mem_addr == h_addr && o_mem_we == h_we && o_mem_wdata == h_wdata &&
            o_mem_be == h_be && o_busy, "hold_stable", o_mem_addr, h_addr);
      end
      if (o_if_ack) begin
        if (if_exp_q.size() == 0) chk(1'b0, "if_ack_unexpected", o_if_rdata, 32'd0);
        else begin
          e = if_exp_q.pop_front();
          chk(o_if_rdata == e, "if_rdata", o_if_rdata, e);
        end
      end
      if (o_dm_ack) begin
        if (dm_exp_q.size() == 0) chk(1'b0, "dm_ack_unexpected", o_dm_rdata, 32'd0);
        else begin
          e = dm_exp_q.pop_front();
          chk(o_dm_rdata == e, "dm_rdata", o_dm_rdata, e);
        end
      end
      if (o_if_ack || o_dm_ack) chk(!(o_if_ack && o_dm_ack), "ack_exclusive", 32'(o_if_ack), 32'd0);
      prev_req = o_mem_req;
    end
  end

  task automatic wait_if_ack(input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = o_if_ack;
    end
    chk(seen, nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_dm_ack(input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = o_dm_ack;
    end
    chk(seen, nm, 32'(seen), 32'd1);
  endtask

  task automatic dm_do(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp);
    dm_exp_q.push_back(exp);
    i_dm_req = 1'b1; i_dm_we = we; i_dm_addr = addr; i_dm_wdata = wdata; i_dm_be = be;
    wait_dm_ack("dm_ack_timeout");
  endtask

  task automatic if_do(input logic [31:0] addr, input logic [31:0] exp);
    if_exp_q.push_back(exp);
    i_if_req = 1'b1; i_if_addr = addr;
    wait_if_ack("if_ack_timeout");
  endtask

  task automatic chk_all_zero(input string nm);
    chk({o_mem_req, o_mem_we, o_mem_be, o_if_ack, o_dm_ack, o_busy} == '0, nm,
        32'({o_mem_req, o_mem_we, o_mem_be, o_if_ack, o_dm_ack, o_busy}), 32'd0);
    chk((o_mem_addr | o_mem_wdata | o_if_rdata | o_dm_rdata) == 32'd0, {nm, "_data"},
        o_mem_addr | o_mem_wdata | o_if_rdata | o_dm_rdata, 32'd0);
  endtask

  logic [31:0] s_addr [8];
  logic [31:0] s_exp  [8];

  initial begin
    i_reset_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_if_flush = 1'b0;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
    s_addr = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014, 32'h3018, 32'h301C};
    s_exp  = '{32'h3113, 32'h3117, 32'h311B, 32'h311F, 32'h3103, 32'h3107, 32'h310B, 32'h310F};
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    i_reset_n = 1'b1;

    // Fetch-only, zero-wait memory: request cycle 1, ack cycle 2.
    push_grant(1'b0, 32'h100, 32'h0, 4'hF);
    if_exp_q.push_back(32'h0000_0013);
    i_if_req = 1'b1; i_if_addr = 32'h100;
    @(negedge clk);
    chk(o_mem_req == 1'b1, "t1_req_cycle1", 32'(o_mem_req), 32'd1);
    @(negedge clk);
    chk(o_if_ack == 1'b1, "t1_ack_cycle2", 32'(o_if_ack), 32'd1);
    i_if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous requests: data write first, then fetch.
    push_grant(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3);
    push_grant(1'b0, 32'h104, 32'h0, 4'hF);
    fork
      begin dm_do(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 32'h0); i_dm_req = 1'b0; end
      begin if_do(32'h104, 32'h0000_0017); i_if_req = 1'b0; end
    join
    repeat (2) @(negedge clk);

    // Continuous traffic: 4 data, 1 fetch, 4 data, 1 fetch.
    for (int i = 0; i < 4; i++) push_grant(1'b0, s_addr[i], 32'h0, 4'hF);
    push_grant(1'b0, 32'h400, 32'h0, 4'hF);
    for (int i = 4; i < 8; i++) push_grant(1'b0, s_addr[i], 32'h0, 4'hF);
    push_grant(1'b0, 32'h404, 32'h0, 4'hF);
    fork
      begin
        for (int i = 0; i < 8; i++) dm_do(1'b0, s_addr[i], 32'h0, 4'hF, s_exp[i]);
        i_dm_req = 1'b0;
      end
      begin
        if_do(32'h400, 32'h0000_0513);
        if_do(32'h404, 32'h0000_0517);
        i_if_req = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Flush during a 3-cycle memory wait, then refetch from the redirected address.
    mem_delay = 3;
    push_grant(1'b0, 32'h500, 32'h0, 4'hF);
    push_grant(1'b0, 32'h600, 32'h0, 4'hF);
    if_exp_q.push_back(32'h0000_0713);
    i_if_req = 1'b1; i_if_addr = 32'h500;
    for (int n = 0; n < 20 && !o_mem_req; n++) @(negedge clk);
    chk(o_mem_req == 1'b1, "t4_req_seen", 32'(o_mem_req), 32'd1);
    @(negedge clk);
    i_if_flush = 1'b1; i_if_addr = 32'h600;
    @(negedge clk);
    i_if_flush = 1'b0;
    wait_if_ack("t4_refetch_ack");
    i_if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Long wait: memory-side outputs held constant.
    mem_delay = 5;
    push_grant(1'b1, 32'h2040, 32'h1234_5678, 4'hC);
    dm_do(1'b1, 32'h2040, 32'h1234_5678, 4'hC, 32'h0);
    i_dm_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-transaction, then a stray memory ack in IDLE.
    mem_en = 1'b0;
    mem_delay = 0;
    push_grant(1'b0, 32'h2080, 32'h0, 4'hF);
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h2080; i_dm_be = 4'hF;
    repeat (3) @(negedge clk);
    chk(o_busy == 1'b1, "t6_busy_before_reset", 32'(o_busy), 32'd1);
    i_reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_after_reset");
    i_reset_n = 1'b1; i_dm_req = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk_all_zero("t6_stray_ack");
    @(negedge clk);
    chk_all_zero("t6_idle");

    chk(gnt_q.size() == 0, "grant_queue_empty", 32'(gnt_q.size()), 32'd0);
    chk(if_exp_q.size() == 0, "if_queue_empty", 32'(if_exp_q.size()), 32'd0);
    chk(dm_exp_q.size() == 0, "dm_queue_empty", 32'(dm_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbiter and sequencer for a single unified memory port shared by the IF stage's instruction fetch and the MEM stage's data access.
- Sits between the fetch path (which drives the instruction address) and the data path on one side, and the external memory's request/acknowledge port on the other.
- Grants one transaction at a time. Data access has priority; a bounded starvation guard guarantees fetch progress.
- Supports a fetch flush, which discards an in-flight fetch result after a branch redirect.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is waiting before fetch is forced. Legal range 1..15.
- AW, 32: address width.
- DW, 32: data width. Byte-enable width is DW/8.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_if_req  in  1  fetch request; held until o_if_ack or until flushed.
- i_if_addr  in  AW  fetch address; stable while i_if_req is high.
- i_if_flush  in  1  one-cycle pulse; cancels the pending or in-flight fetch.
- o_if_ack  out  1  one-cycle pulse; o_if_rdata is valid in that cycle.
- o_if_rdata  out  DW  fetched instruction.
- i_dm_req  in  1  data request; held until o_dm_ack.
- i_dm_we  in  1  1 = write, 0 = read.
- i_dm_addr  in  AW  data address.
- i_dm_wdata  in  DW  write data.
- i_dm_be  in  DW/8  byte enables.
- o_dm_ack  out  1  one-cycle completion pulse.
- o_dm_rdata  out  DW  read data, valid while o_dm_ack is high.
- o_mem_req  out  1  memory request; held high until i_mem_ack.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory write data.
- o_mem_be  out  DW/8  memory byte enables.
- i_mem_ack  in  1  one-cycle acknowledge from memory.
- i_mem_rdata  in  DW  memory read data, valid with i_mem_ack.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (i_reset_n low at a rising edge):
  - State goes to IDLE; starvation counter = 0; discard flag = 0.
  - All outputs = 0.
  - Reset mid-transaction abandons the transaction: o_mem_req drops and no ack is issued.
  - An i_mem_ack arriving while in IDLE is ignored.
- States: IDLE, IF_BUSY, DM_BUSY. All memory-side outputs and acks are registered.
- Arbitration in IDLE:
  - If i_dm_req is high and (i_if_req is low or counter < STARVE_MAX): grant data and go to DM_BUSY. If i_if_req is high, counter++; otherwise counter = 0.
  - Else if i_if_req is high and i_if_flush is low: grant fetch, go to IF_BUSY, counter = 0.
  - Else remain in IDLE; if i_if_req is low, counter = 0.
- On a grant, the next cycle drives:
  - o_mem_req = 1.
  - The latched address, we, wdata and be.
  - Fetch grants use we = 0 and be = all ones.
  - The memory-side outputs stay constant until i_mem_ack.
- Completion:
  - A cycle with i_mem_ack high while BUSY: next cycle o_mem_req = 0, state = IDLE.
  - The matching ack (o_if_ack or o_dm_ack) pulses for one cycle, with rdata registered from i_mem_rdata.
  - For writes, o_dm_rdata = 0.
- Latency:
  - Request seen in IDLE at cycle N: o_mem_req at N+1; with zero-wait memory (ack at N+1), requester ack at N+2.
  - Back-to-back transactions: the next o_mem_req rises no earlier than N+3, giving one idle memory cycle between transactions.
- Flush:
  - i_if_flush in IDLE blocks the fetch grant that cycle. Data may still be granted.
  - i_if_flush in IF_BUSY (including the ack cycle) sets the discard flag. The memory transaction still completes, o_if_ack is suppressed, and the flag clears on return to IDLE.
  - Flush in DM_BUSY has no effect.
- Simultaneous events: i_mem_ack with i_if_flush in the same IF_BUSY cycle means no o_if_ack.
- Counter saturates at STARVE_MAX.
- o_if_ack and o_dm_ack are never high in the same cycle.

Test Plan:
- Reset, then fetch-only with i_if_addr=0x100 and zero-wait memory returning 0x00000013 -> o_mem_req at cycle 1 with o_mem_addr=0x100, we=0, be=0xF; o_if_ack at cycle 2 with o_if_rdata=0x00000013.
- i_if_req and i_dm_req both high, dm write addr=0x2000, wdata=0xDEADBEEF, be=0x3 -> data granted first with o_mem_we=1 and o_mem_be=0x3; o_dm_ack, then fetch granted next.
- Continuous dm_req and if_req, STARVE_MAX=4 -> grant order is 4 data, 1 fetch, 4 data, 1 fetch; no fetch waits longer than 4 data transactions.
- Fetch granted, memory waits 3 cycles, i_if_flush pulsed during the wait -> o_mem_req stays high until ack and drops the cycle after; no o_if_ack; the next fetch uses the new address.
- Memory with 5-cycle ack delay -> o_mem_addr, we, be and wdata stay constant for all 5 cycles; o_busy stays high.
- Reset asserted mid DM_BUSY, then a stray i_mem_ack -> all outputs 0, no o_dm_ack, state IDLE.
